// File: rtl/rvh_pmp_chk_arb.sv
`default_nettype none
// ============================================================================
// rvh_pmp_chk_arb : round-robin issue stage for PMP checks, with tagged
//                   responses, sticky first-fault record and fault counter.
// Rev 1.0
// ============================================================================
module rvh_pmp_chk_arb #(
  parameter int NUM_REQ     = 3,
  parameter int PADDR_WIDTH = 56,
  parameter int ID_WIDTH    = 4,
  parameter int PMP_LAT     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_vld_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  input  logic [NUM_REQ*PADDR_WIDTH-1:0] req_paddr_i,
  input  logic [NUM_REQ*2-1:0]           req_access_type_i,
  input  logic [NUM_REQ*ID_WIDTH-1:0]    req_id_i,
  output logic                           pmp_chk_vld_o,
  output logic [PADDR_WIDTH-1:0]         pmp_chk_paddr_o,
  output logic [1:0]                     pmp_chk_type_o,
  input  logic                           pmp_chk_fail_i,
  output logic                           resp_vld_o,
  output logic [NUM_REQ-1:0]             resp_src_o,
  output logic [ID_WIDTH-1:0]            resp_id_o,
  output logic                           resp_fail_o,
  output logic                           fault_vld_o,
  output logic [PADDR_WIDTH-1:0]         fault_paddr_o,
  output logic [NUM_REQ-1:0]             fault_src_o,
  input  logic                           fault_clr_i,
  output logic [15:0]                    fault_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     win_oh;
  logic                   win_found;
  logic                   accept;
  logic [PADDR_WIDTH-1:0] sel_paddr;
  logic [1:0]             sel_type;
  logic [ID_WIDTH-1:0]    sel_id;

  // Scan from ptr upward, wrapping at NUM_REQ; first valid source wins.
  always_comb begin : arb
    int               idx;
    int               nxt;
    logic [PTR_W-1:0] idx_l;
    win_oh    = '0;
    win_found = 1'b0;
    ptr_d     = ptr_q;
    idx       = 0;
    nxt       = 0;
    idx_l     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_l = PTR_W'(idx);
      if (!win_found && req_vld_i[idx_l]) begin
        win_found     = 1'b1;
        win_oh[idx_l] = 1'b1;
        nxt           = (idx + 1 >= NUM_REQ) ? 0 : idx + 1;
        ptr_d         = PTR_W'(nxt);
      end
    end
  end

  always_comb begin : payload_mux
    sel_paddr = '0;
    sel_type  = '0;
    sel_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel_paddr = req_paddr_i[i*PADDR_WIDTH +: PADDR_WIDTH];
        sel_type  = req_access_type_i[i*2 +: 2];
        sel_id    = req_id_i[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  assign accept    = win_found & ~flush_i;
  assign req_rdy_o = accept ? win_oh : '0;

  logic                   chk_vld_q;
  logic [PADDR_WIDTH-1:0] chk_paddr_q;
  logic [1:0]             chk_type_q;
  logic [NUM_REQ-1:0]     chk_src_q;
  logic [ID_WIDTH-1:0]    chk_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      chk_vld_q   <= 1'b0;
      chk_paddr_q <= '0;
      chk_type_q  <= '0;
      chk_src_q   <= '0;
      chk_id_q    <= '0;
    end else begin
      chk_vld_q <= accept;
      if (accept) begin
        ptr_q       <= ptr_d;
        chk_paddr_q <= sel_paddr;
        chk_type_q  <= sel_type;
        chk_src_q   <= win_oh;
        chk_id_q    <= sel_id;
      end
    end
  end

  assign pmp_chk_vld_o   = chk_vld_q;
  assign pmp_chk_paddr_o = chk_paddr_q;
  assign pmp_chk_type_o  = chk_type_q;

  // Stage whose valid qualifies pmp_chk_fail_i, depending on PMP latency.
  logic                   stg_vld;
  logic [NUM_REQ-1:0]     stg_src;
  logic [ID_WIDTH-1:0]    stg_id;
  logic [PADDR_WIDTH-1:0] stg_paddr;

  if (PMP_LAT == 0) begin : g_lat0
    assign stg_vld   = chk_vld_q;
    assign stg_src   = chk_src_q;
    assign stg_id    = chk_id_q;
    assign stg_paddr = chk_paddr_q;
  end else begin : g_lat1
    logic                   tag_vld_q;
    logic [NUM_REQ-1:0]     tag_src_q;
    logic [ID_WIDTH-1:0]    tag_id_q;
    logic [PADDR_WIDTH-1:0] tag_paddr_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        tag_vld_q   <= 1'b0;
        tag_src_q   <= '0;
        tag_id_q    <= '0;
        tag_paddr_q <= '0;
      end else begin
        tag_vld_q <= chk_vld_q & ~flush_i;
        if (chk_vld_q) begin
          tag_src_q   <= chk_src_q;
          tag_id_q    <= chk_id_q;
          tag_paddr_q <= chk_paddr_q;
        end
      end
    end

    assign stg_vld   = tag_vld_q;
    assign stg_src   = tag_src_q;
    assign stg_id    = tag_id_q;
    assign stg_paddr = tag_paddr_q;
  end

  logic                   resp_load;
  logic                   resp_vld_q;
  logic [NUM_REQ-1:0]     resp_src_q;
  logic [ID_WIDTH-1:0]    resp_id_q;
  logic                   resp_fail_q;
  logic [PADDR_WIDTH-1:0] resp_paddr_q;

  assign resp_load = stg_vld & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_vld_q   <= 1'b0;
      resp_src_q   <= '0;
      resp_id_q    <= '0;
      resp_fail_q  <= 1'b0;
      resp_paddr_q <= '0;
    end else begin
      resp_vld_q <= resp_load;
      if (resp_load) begin
        resp_src_q   <= stg_src;
        resp_id_q    <= stg_id;
        resp_fail_q  <= pmp_chk_fail_i;
        resp_paddr_q <= stg_paddr;
      end
    end
  end

  assign resp_vld_o  = resp_vld_q;
  assign resp_src_o  = resp_src_q;
  assign resp_id_o   = resp_id_q;
  assign resp_fail_o = resp_fail_q;

  logic                   fail_rsp;
  logic                   fault_cap;
  logic                   fault_vld_q;
  logic [PADDR_WIDTH-1:0] fault_paddr_q;
  logic [NUM_REQ-1:0]     fault_src_q;
  logic [15:0]            fault_cnt_q;

  // A clear coinciding with a new fault re-arms capture, so the new fault lands.
  assign fail_rsp  = resp_vld_q & resp_fail_q;
  assign fault_cap = fail_rsp & (~fault_vld_q | fault_clr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_vld_q   <= 1'b0;
      fault_paddr_q <= '0;
      fault_src_q   <= '0;
      fault_cnt_q   <= '0;
    end else begin
      if (fault_cap) begin
        fault_vld_q   <= 1'b1;
        fault_paddr_q <= resp_paddr_q;
        fault_src_q   <= resp_src_q;
      end else if (fault_clr_i) begin
        fault_vld_q   <= 1'b0;
        fault_paddr_q <= '0;
        fault_src_q   <= '0;
      end
      if (fail_rsp && (fault_cnt_q != 16'hFFFF)) begin
        fault_cnt_q <= fault_cnt_q + 16'd1;
      end
    end
  end

  assign fault_vld_o   = fault_vld_q;
  assign fault_paddr_o = fault_paddr_q;
  assign fault_src_o   = fault_src_q;
  assign fault_cnt_o   = fault_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rvh_pmp_chk_arb.sv
`default_nettype none
// ============================================================================
// tb_rvh_pmp_chk_arb : directed bench, one instance per PMP latency.
// Rev 1.0
// ============================================================================
module tb_rvh_pmp_chk_arb;
  localparam int N  = 3;
  localparam int AW = 56;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, clr, fail0, fail1;
  logic [N-1:0]    vld;
  logic [N*AW-1:0] paddr;
  logic [N*2-1:0]  atype;
  logic [N*IW-1:0] id;

  logic [N-1:0]  rdy0, rs0, fs0, rdy1, rs1, fs1;
  logic          cv0, rv0, rf0, fv0, cv1, rv1, rf1, fv1;
  logic [AW-1:0] cp0, fp0, cp1, fp1;
  logic [1:0]    ct0, ct1;
  logic [IW-1:0] ri0, ri1;
  logic [15:0]   fc0, fc1;

  rvh_pmp_chk_arb #(.NUM_REQ(N), .PADDR_WIDTH(AW), .ID_WIDTH(IW), .PMP_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req_vld_i(vld), .req_rdy_o(rdy0), .req_paddr_i(paddr),
    .req_access_type_i(atype), .req_id_i(id),
    .pmp_chk_vld_o(cv0), .pmp_chk_paddr_o(cp0), .pmp_chk_type_o(ct0),
    .pmp_chk_fail_i(fail0),
    .resp_vld_o(rv0), .resp_src_o(rs0), .resp_id_o(ri0), .resp_fail_o(rf0),
    .fault_vld_o(fv0), .fault_paddr_o(fp0), .fault_src_o(fs0),
    .fault_clr_i(clr), .fault_cnt_o(fc0)
  );

  rvh_pmp_chk_arb #(.NUM_REQ(N), .PADDR_WIDTH(AW), .ID_WIDTH(IW), .PMP_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req_vld_i(vld), .req_rdy_o(rdy1), .req_paddr_i(paddr),
    .req_access_type_i(atype), .req_id_i(id),
    .pmp_chk_vld_o(cv1), .pmp_chk_paddr_o(cp1), .pmp_chk_type_o(ct1),
    .pmp_chk_fail_i(fail1),
    .resp_vld_o(rv1), .resp_src_o(rs1), .resp_id_o(ri1), .resp_fail_o(rf1),
    .fault_vld_o(fv1), .fault_paddr_o(fp1), .fault_src_o(fs1),
    .fault_clr_i(clr), .fault_cnt_o(fc1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [1:0] t,
                         input logic [IW-1:0] d);
    paddr[i*AW +: AW] = a;
    atype[i*2 +: 2]   = t;
    id[i*IW +: IW]    = d;
  endtask

  logic [N-1:0]  g_exp [6];
  logic [IW-1:0] i_exp [6];

  initial begin
    g_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    i_exp = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3};
    rst = 1'b1; flush = 1'b0; clr = 1'b0; fail0 = 1'b0; fail1 = 1'b0;
    vld = '0; paddr = '0; atype = '0; id = '0;
    tick; tick;

    // reset state
    check("rst_chk_vld", cv0, 0);
    check("rst_resp_vld", rv0, 0);
    check("rst_fault_vld", fv0, 0);
    check("rst_fault_cnt", fc0, 0);
    check("rst_chk_paddr", cp0, 0);
    rst = 1'b0;
    tick;

    // single request from src1, pass
    set_src(1, 56'h8000_0000, 2'b01, 4'h3);
    vld = 3'b010; #1;
    check("t1_rdy", rdy0, 3'b010);
    tick;
    vld = '0; #1;
    check("t1_chk_vld", cv0, 1);
    check("t1_chk_paddr", cp0, 56'h8000_0000);
    check("t1_chk_type", ct0, 2'b01);
    check("t1_resp_early", rv0, 0);
    tick;
    check("t1_resp_vld", rv0, 1);
    check("t1_resp_src", rs0, 3'b010);
    check("t1_resp_id", ri0, 4'h3);
    check("t1_resp_fail", rf0, 0);
    tick;
    check("t1_resp_once", rv0, 0);

    // round robin, all sources valid for six cycles from ptr 0
    rst = 1'b1; tick; rst = 1'b0;
    set_src(0, 56'h10, 2'b00, 4'h1);
    set_src(1, 56'h20, 2'b00, 4'h2);
    set_src(2, 56'h30, 2'b00, 4'h3);
    for (int k = 0; k < 8; k++) begin
      vld = (k < 6) ? 3'b111 : 3'b000; #1;
      if (k < 6) check("t2_rdy", rdy0, g_exp[k]);
      if (k >= 2) begin
        check("t2_resp_vld", rv0, 1);
        check("t2_resp_src", rs0, g_exp[k-2]);
        check("t2_resp_id", ri0, i_exp[k-2]);
      end
      tick;
    end
    check("t2_drain", rv0, 0);

    // flush kills the second of two back-to-back accepts
    set_src(0, 56'h100, 2'b00, 4'hA);
    set_src(1, 56'h200, 2'b00, 4'hB);
    set_src(2, 56'h300, 2'b00, 4'hC);
    vld = 3'b001; #1;
    check("t4_rdy_a", rdy0, 3'b001);
    tick;
    vld = 3'b010; #1;
    check("t4_rdy_b", rdy0, 3'b010);
    tick;
    flush = 1'b1; vld = 3'b100; #1;
    check("t4_rdy_flush", rdy0, 3'b000);
    check("t4_resp_vld", rv0, 1);
    check("t4_resp_src", rs0, 3'b001);
    check("t4_resp_id", ri0, 4'hA);
    tick;
    flush = 1'b0; vld = '0; #1;
    check("t4_chk_killed", cv0, 0);
    check("t4_no_resp", rv0, 0);
    tick;
    check("t4_no_resp_late", rv0, 0);

    // PMP_LAT=1 failing check from src2
    set_src(2, 56'h12_3456_7000, 2'b10, 4'h5);
    vld = 3'b100; #1;
    check("t3_rdy", rdy1, 3'b100);
    tick;
    vld = '0; #1;
    check("t3_chk_vld", cv1, 1);
    check("t3_chk_paddr", cp1, 56'h12_3456_7000);
    tick;
    fail1 = 1'b1;
    check("t3_resp_early", rv1, 0);
    tick;
    fail1 = 1'b0;
    check("t3_resp_vld", rv1, 1);
    check("t3_resp_id", ri1, 4'h5);
    check("t3_resp_fail", rf1, 1);
    check("t3_resp_src", rs1, 3'b100);
    check("t3_fault_not_yet", fv1, 0);
    tick;
    check("t3_fault_vld", fv1, 1);
    check("t3_fault_paddr", fp1, 56'h12_3456_7000);
    check("t3_fault_src", fs1, 3'b100);
    check("t3_fault_cnt", fc1, 1);

    // first fault, then clear coinciding with second fault
    set_src(0, 56'h1000, 2'b00, 4'h1);
    vld = 3'b001; #1;
    check("t5_rdy_a", rdy0, 3'b001);
    tick;
    vld = '0; fail0 = 1'b1;
    tick;
    fail0 = 1'b0;
    check("t5_fail_a", rf0, 1);
    tick;
    check("t5_fv_a", fv0, 1);
    check("t5_fp_a", fp0, 56'h1000);
    check("t5_cnt_a", fc0, 1);
    set_src(1, 56'h2000, 2'b00, 4'h2);
    vld = 3'b010;
    tick;
    vld = '0; fail0 = 1'b1;
    tick;
    fail0 = 1'b0; clr = 1'b1;
    check("t5_fail_b", rf0, 1);
    check("t5_fp_hold", fp0, 56'h1000);
    tick;
    clr = 1'b0;
    check("t5_fv_b", fv0, 1);
    check("t5_fp_b", fp0, 56'h2000);
    check("t5_fs_b", fs0, 3'b010);
    check("t5_cnt_b", fc0, 2);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    check("t5_cleared", fv0, 0);
    check("t5_cnt_kept", fc0, 2);

    // counter saturation, then reset mid-stream
    vld = 3'b111; fail0 = 1'b1;
    repeat (65540) tick;
    check("t6_sat", fc0, 16'hFFFF);
    check("t6_fv", fv0, 1);
    repeat (5) tick;
    check("t6_sat_hold", fc0, 16'hFFFF);
    check("t6_busy", rv0, 1);
    rst = 1'b1; vld = '0; fail0 = 1'b0;
    tick;
    check("t6_rst_chk_vld", cv0, 0);
    check("t6_rst_chk_paddr", cp0, 0);
    check("t6_rst_resp_vld", rv0, 0);
    check("t6_rst_resp_src", rs0, 0);
    check("t6_rst_resp_fail", rf0, 0);
    check("t6_rst_fv", fv0, 0);
    check("t6_rst_fp", fp0, 0);
    check("t6_rst_fs", fs0, 0);
    check("t6_rst_cnt", fc0, 0);
    rst = 1'b0;
    tick;
    check("t6_post_resp", rv0, 0);
    check("t6_post_chk", cv0, 0);
    tick;
    check("t6_post_resp2", rv0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
